fpu_mult_pipe: RTL and testbench

Parametrised IEEE-754-style floating-point multiplier, next generation of the team's fixed FP16 multiplier. Format width, rounding mode and exception flags are configurable. Three-stage pipeline with full valid/ready backpressure, so it can sit behind the FPU issue logic and ahead of a stalling writeback. Default parameters give binary16.

---
 rtl/fpu_mult_pipe_if.sv | 28 ++
 rtl/fpu_mult_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_fpu_mult_pipe.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_mult_pipe_if.sv
// Operand/result handshake bundle for fpu_mult_pipe.
// The master drives operands and out_ready; the slave (the multiplier) drives results and in_ready.
interface fpu_mult_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         rnd_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, rnd_mode, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, rnd_mode, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fpu_mult_pipe.sv
// Three-stage floating-point multiplier with valid/ready backpressure; binary16 by default.
// Define FPU_MULT_RTZ_EN to honour rnd_mode (round-toward-zero); otherwise RNE is always used.
module fpu_mult_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic           clk,
   input  logic           rst,
   fpu_mult_pipe_if.slave mif
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int PW = 2 * SW;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
   localparam logic [EXP_W-1:0]     EXP_ONES = '1;
   localparam logic [EXP_W-1:0]     EXP_MAXF = EXP_ONES - 1'b1;
   localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
      return guard && (sticky || lsb);
   endfunction

   function automatic logic [W-1:0] ovf_result(input logic sign, input logic rtz);
      return rtz ? {sign, EXP_MAXF, {MAN_W{1'b1}}} : {sign, EXP_ONES, {MAN_W{1'b0}}};
   endfunction

   logic en1, en2, en3, ld1, ld2, ld3;

   logic                 sa, sb;
   logic [EXP_W-1:0]     ea, eb;
   logic [MAN_W-1:0]     ma, mb;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic                 spec_new;
   logic [W-1:0]         sres_new;
   logic [3:0]           sflg_new;

   logic                 vld_p1_d, vld_p1_q, sign_p1_d, sign_p1_q, spec_p1_d, spec_p1_q;
   logic                 rtz_p1_d, rtz_p1_q;
   logic signed [EW-1:0] exp_p1_d, exp_p1_q;
   logic [SW-1:0]        siga_p1_d, siga_p1_q, sigb_p1_d, sigb_p1_q;
   logic [W-1:0]         sres_p1_d, sres_p1_q;
   logic [3:0]           sflg_p1_d, sflg_p1_q;

   logic                 vld_p2_d, vld_p2_q, sign_p2_d, sign_p2_q, spec_p2_d, spec_p2_q;
   logic                 rtz_p2_d, rtz_p2_q;
   logic signed [EW-1:0] exp_p2_d, exp_p2_q;
   logic [PW-1:0]        prod_p2_d, prod_p2_q;
   logic [W-1:0]         sres_p2_d, sres_p2_q;
   logic [3:0]           sflg_p2_d, sflg_p2_q;

   logic [PW-2:0]        norm;
   logic [MAN_W-1:0]     man_t;
   logic [MAN_W:0]       man_r;
   logic                 guard, sticky, inc;
   logic signed [EW-1:0] exp_n, exp_r;
   logic [W-1:0]         res_new;
   logic [3:0]           flg_new;

   logic                 vld_p3_d, vld_p3_q;
   logic [W-1:0]         res_p3_d, res_p3_q;
   logic [3:0]           flg_p3_d, flg_p3_q;

   // Each stage loads when it is empty or its successor is taking its contents.
   always_comb begin
      en3 = !vld_p3_q || mif.out_ready;
      en2 = !vld_p2_q || en3;
      en1 = !vld_p1_q || en2;
      ld1 = en1 && mif.in_valid;
      ld2 = en2 && vld_p1_q;
      ld3 = en3 && vld_p2_q;
   end

   assign mif.in_ready  = en1;
   assign mif.out_valid = vld_p3_q;
   assign mif.result    = res_p3_q;
   assign mif.flags     = flg_p3_q;

   // Stage 1: unpack, classify, resolve specials, sum exponents.
   always_comb begin
      {sa, ea, ma} = mif.a;
      {sb, eb, mb} = mif.b;
      // A zero exponent field covers both zero and subnormal; subnormals flush silently.
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == EXP_ONES) && (ma == '0);
      b_inf  = (eb == EXP_ONES) && (mb == '0);
      a_nan  = (ea == EXP_ONES) && (ma != '0);
      b_nan  = (eb == EXP_ONES) && (mb != '0);
      a_snan = a_nan && !ma[MAN_W-1];
      b_snan = b_nan && !mb[MAN_W-1];

      spec_new = 1'b1;
      sres_new = '0;
      sflg_new = '0;
      if (a_nan || b_nan) begin
         sres_new = QNAN;
         sflg_new = {a_snan || b_snan, 3'b000};
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         sres_new = QNAN;
         sflg_new = 4'b1000;
      end else if (a_inf || b_inf) begin
         sres_new = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         sres_new = {sa ^ sb, {(W-1){1'b0}}};
      end else begin
         spec_new = 1'b0;
      end

      vld_p1_d  = en1 ? mif.in_valid : vld_p1_q;
      sign_p1_d = ld1 ? (sa ^ sb) : sign_p1_q;
      exp_p1_d  = ld1 ? ($signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS) : exp_p1_q;
      siga_p1_d = ld1 ? {1'b1, ma} : siga_p1_q;
      sigb_p1_d = ld1 ? {1'b1, mb} : sigb_p1_q;
      spec_p1_d = ld1 ? spec_new : spec_p1_q;
      sres_p1_d = ld1 ? sres_new : sres_p1_q;
      sflg_p1_d = ld1 ? sflg_new : sflg_p1_q;
`ifdef FPU_MULT_RTZ_EN
      rtz_p1_d  = ld1 ? mif.rnd_mode : rtz_p1_q;
`else
      rtz_p1_d  = 1'b0;
`endif
   end

   // Stage 2: significand product including hidden bits.
   always_comb begin
      vld_p2_d  = en2 ? vld_p1_q : vld_p2_q;
      sign_p2_d = ld2 ? sign_p1_q : sign_p2_q;
      exp_p2_d  = ld2 ? exp_p1_q : exp_p2_q;
      prod_p2_d = ld2 ? (PW'(siga_p1_q) * PW'(sigb_p1_q)) : prod_p2_q;
      spec_p2_d = ld2 ? spec_p1_q : spec_p2_q;
      sres_p2_d = ld2 ? sres_p1_q : sres_p2_q;
      sflg_p2_d = ld2 ? sflg_p1_q : sflg_p2_q;
      rtz_p2_d  = ld2 ? rtz_p1_q : rtz_p2_q;
   end

   // Stage 3: normalise, round, range-check, select special result.
   always_comb begin
      norm   = prod_p2_q[PW-1] ? prod_p2_q[PW-2:0] : {prod_p2_q[PW-3:0], 1'b0};
      exp_n  = exp_p2_q + $signed(EW'(prod_p2_q[PW-1]));
      man_t  = norm[PW-2 -: MAN_W];
      guard  = norm[MAN_W];
      sticky = |norm[MAN_W-1:0];
      inc    = rne_inc(man_t[0], guard, sticky) && !rtz_p2_q;
      man_r  = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
      // A rounding carry-out leaves the low mantissa bits zero; only the exponent moves.
      exp_r  = exp_n + $signed(EW'(man_r[MAN_W]));

      res_new = {sign_p2_q, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
      flg_new = {3'b000, guard || sticky};
      if (spec_p2_q) begin
         res_new = sres_p2_q;
         flg_new = sflg_p2_q;
      end else if (exp_r >= EMAX) begin
         res_new = ovf_result(sign_p2_q, rtz_p2_q);
         flg_new = 4'b0101;
      end else if (exp_r[EW-1] || (exp_r == '0)) begin
         res_new = {sign_p2_q, {(W-1){1'b0}}};
         flg_new = 4'b0011;
      end

      vld_p3_d = en3 ? vld_p2_q : vld_p3_q;
      res_p3_d = ld3 ? res_new : res_p3_q;
      flg_p3_d = ld3 ? flg_new : flg_p3_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         res_p3_q <= '0;
         flg_p3_q <= '0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         vld_p3_q <= vld_p3_d;
         res_p3_q <= res_p3_d;
         flg_p3_q <= flg_p3_d;
      end
   end

   always_ff @(posedge clk) begin
      sign_p1_q <= sign_p1_d;
      exp_p1_q  <= exp_p1_d;
      siga_p1_q <= siga_p1_d;
      sigb_p1_q <= sigb_p1_d;
      spec_p1_q <= spec_p1_d;
      sres_p1_q <= sres_p1_d;
      sflg_p1_q <= sflg_p1_d;
      rtz_p1_q  <= rtz_p1_d;
      sign_p2_q <= sign_p2_d;
      exp_p2_q  <= exp_p2_d;
      prod_p2_q <= prod_p2_d;
      spec_p2_q <= spec_p2_d;
      sres_p2_q <= sres_p2_d;
      sflg_p2_q <= sflg_p2_d;
      rtz_p2_q  <= rtz_p2_d;
   end
endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Scoreboard bench for fpu_mult_pipe (binary16): directed vectors with hand-computed results,
// backpressure with in-order drain, and reset with operations in flight.
module tb_fpu_mult_pipe;
   localparam int EXP_W = 5;
   localparam int MAN_W = 10;

`ifdef FPU_MULT_RTZ_EN
   localparam logic [15:0] OVF_RTZ   = 16'h7BFF;
   localparam logic [15:0] TRUNC_RTZ = 16'h4081;
`else
   localparam logic [15:0] OVF_RTZ   = 16'h7C00;
   localparam logic [15:0] TRUNC_RTZ = 16'h4082;
`endif

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flg;
      int          acc;
      bit          lat;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   fpu_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) mif ();

   fpu_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk (clk),
      .rst (rst),
      .mif (mif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Issue one operand pair, waiting (bounded) for in_ready; the expected result joins the scoreboard.
   task automatic issue(input string name, input logic [15:0] va, input logic [15:0] vb,
                        input logic rm, input logic [15:0] er, input logic [3:0] ef, input bit lat);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      mif.in_valid = 1'b1;
      mif.a        = va;
      mif.b        = vb;
      mif.rnd_mode = rm;
      while (!done) begin
         @(negedge clk);
         if (mif.in_ready) begin
            sb_q.push_back('{res: er, flg: ef, acc: cyc, lat: lat, name: name});
            done = 1'b1;
         end else begin
            n++;
            if (n > 50) begin
               checks++;
               errors++;
               $display("FAIL %s_accept: in_ready low for %0d cycles, required acceptance", name, n);
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
      mif.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({name, "_pending"}, 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: whenever a result is presented, compare it to the scoreboard head; pop on transfer.
   initial forever begin
      @(negedge clk);
      if (!rst && mif.out_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: result %h flags %h presented, required no output", mif.result, mif.flags);
         end else begin
            check({sb_q[0].name, "_res"}, 32'(mif.result), 32'(sb_q[0].res));
            check({sb_q[0].name, "_flg"}, 32'(mif.flags), 32'(sb_q[0].flg));
            if (mif.out_ready) begin
               if (sb_q[0].lat) check({sb_q[0].name, "_lat"}, 32'(cyc - sb_q[0].acc), 32'd3);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      mif.in_valid  = 1'b0;
      mif.a         = '0;
      mif.b         = '0;
      mif.rnd_mode  = 1'b0;
      mif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(mif.out_valid), 32'd0);
      check("rst_result", 32'(mif.result), 32'd0);
      check("rst_flags", 32'(mif.flags), 32'd0);
      check("rst_in_ready", 32'(mif.in_ready), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue("one_x_two",  16'h3C00, 16'h4000, 1'b0, 16'h4000, 4'h0, 1'b1);
      issue("sq_1p5",     16'h3E00, 16'h3E00, 1'b0, 16'h4080, 4'h0, 1'b1);
      issue("sq_lsb",     16'h3C01, 16'h3C01, 1'b0, 16'h3C02, 4'h1, 1'b1);
      issue("ovf_rne",    16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5, 1'b1);
      issue("ovf_rtz",    16'h7BFF, 16'h7BFF, 1'b1, OVF_RTZ,  4'h5, 1'b1);
      issue("inf_x_zero", 16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'h8, 1'b1);
      issue("ninf_x_two", 16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'h0, 1'b1);
      issue("snan",       16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'h8, 1'b1);
      issue("qnan",       16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'h0, 1'b1);
      issue("unf_min",    16'h0400, 16'h0400, 1'b0, 16'h0000, 4'h3, 1'b1);
      issue("unf_edge",   16'h2000, 16'h1C00, 1'b0, 16'h0000, 4'h3, 1'b1);
      issue("min_norm",   16'h2000, 16'h2000, 1'b0, 16'h0400, 4'h0, 1'b1);
      issue("ovf_edge",   16'h7800, 16'h4000, 1'b0, 16'h7C00, 4'h5, 1'b1);
      issue("max_fin",    16'h7800, 16'h3FFF, 1'b0, 16'h7BFF, 4'h0, 1'b1);
      issue("rne_up",     16'h3E01, 16'h3E01, 1'b0, 16'h4082, 4'h1, 1'b1);
      issue("rtz_trunc",  16'h3E01, 16'h3E01, 1'b1, TRUNC_RTZ, 4'h1, 1'b1);
      issue("tie_odd",    16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 4'h1, 1'b1);
      issue("tie_even",   16'h3C03, 16'h3E00, 1'b0, 16'h3E04, 4'h1, 1'b1);
      issue("rnd_carry",  16'h3DA8, 16'h3DA8, 1'b0, 16'h4000, 4'h1, 1'b1);
      issue("sub_flush",  16'h0001, 16'h4000, 1'b0, 16'h0000, 4'h0, 1'b1);
      issue("neg_zero",   16'h8000, 16'h4000, 1'b0, 16'h8000, 4'h0, 1'b1);
      issue("inf_x_inf",  16'h7C00, 16'hFC00, 1'b0, 16'hFC00, 4'h0, 1'b1);
      issue("neg_prod",   16'hC000, 16'h4000, 1'b0, 16'hC400, 4'h0, 1'b1);
      drain("directed");

      mif.out_ready = 1'b0;
      fork
         begin
            issue("bp0", 16'h3C00, 16'h4000, 1'b0, 16'h4000, 4'h0, 1'b0);
            issue("bp1", 16'h4000, 16'h4000, 1'b0, 16'h4400, 4'h0, 1'b0);
            issue("bp2", 16'h4200, 16'h4000, 1'b0, 16'h4600, 4'h0, 1'b0);
            issue("bp3", 16'h4400, 16'h4400, 1'b0, 16'h4C00, 4'h0, 1'b0);
            issue("bp4", 16'hC000, 16'h3C00, 1'b0, 16'hC000, 4'h0, 1'b0);
            issue("bp5", 16'h3800, 16'h3800, 1'b0, 16'h3400, 4'h0, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("bp_in_ready_full", 32'(mif.in_ready), 32'd0);
            check("bp_out_valid_held", 32'(mif.out_valid), 32'd1);
            repeat (2) @(posedge clk);
            #1;
            mif.out_ready = 1'b1;
         end
      join
      drain("bp");

      issue("rs0", 16'h3C00, 16'h4000, 1'b0, 16'h4000, 4'h0, 1'b0);
      issue("rs1", 16'h4000, 16'h4000, 1'b0, 16'h4400, 4'h0, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(mif.out_valid), 32'd0);
      check("midrst_result", 32'(mif.result), 32'd0);
      check("midrst_flags", 32'(mif.flags), 32'd0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_in_ready", 32'(mif.in_ready), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      issue("post_rst", 16'h4000, 16'h4200, 1'b0, 16'h4600, 4'h0, 1'b1);
      drain("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
